shift_sub_divider: RTL and testbench

SHIFT_SUB_DIVIDER -- requirements
Module: shift_sub_divider

---
 rtl/shift_sub_divider.sv | 126 ++++++++++++
 tb/tb_shift_sub_divider.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/shift_sub_divider.sv
// Restoring shift-subtract divider: 8-bit dividend by 4-bit divisor, 4-bit quotient/remainder.
// One CHECK cycle screens out divide-by-zero and quotient overflow, then four CALC iterations.
module shift_sub_divider (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [7:0] dividendBus,
  input  logic [3:0] divisorBus,
  output logic       ready,
  output logic       valid,
  output logic [3:0] quotientBus,
  output logic [3:0] remainderBus,
  output logic       divByZero,
  output logic       overflow
);

  typedef enum logic [1:0] {
    IDLE,
    CHECK,
    CALC
  } state_e;

  state_e     state_q, state_d;
  logic [4:0] p_q, p_d;
  logic [3:0] a_q, a_d;
  logic [3:0] d_q, d_d;
  logic [1:0] cnt_q, cnt_d;
  logic       valid_q, valid_d;
  logic       dbz_q, dbz_d;
  logic       ovf_q, ovf_d;

  logic [4:0] shift_p;
  logic [3:0] shift_a;

  always_comb begin
    state_d = state_q;
    p_d     = p_q;
    a_d     = a_q;
    d_d     = d_q;
    cnt_d   = cnt_q;
    valid_d = valid_q;
    dbz_d   = dbz_q;
    ovf_d   = ovf_q;
    // P[4] is always zero between iterations, so the shift drops it
    shift_p = {p_q[3:0], a_q[3]};
    shift_a = {a_q[2:0], 1'b0};

    case (state_q)
      IDLE: begin
        if (start) begin
          p_d     = {1'b0, dividendBus[7:4]};
          a_d     = dividendBus[3:0];
          d_d     = divisorBus;
          valid_d = 1'b0;
          dbz_d   = 1'b0;
          ovf_d   = 1'b0;
          state_d = CHECK;
        end
      end
      CHECK: begin
        if (d_q == 4'd0) begin
          dbz_d   = 1'b1;
          a_d     = '1;
          p_d     = '0;
          valid_d = 1'b1;
          state_d = IDLE;
        end else if (p_q >= {1'b0, d_q}) begin
          // Upper nibble >= divisor means the quotient cannot fit in 4 bits
          ovf_d   = 1'b1;
          a_d     = '1;
          p_d     = '0;
          valid_d = 1'b1;
          state_d = IDLE;
        end else begin
          cnt_d   = '0;
          state_d = CALC;
        end
      end
      CALC: begin
        if (shift_p >= {1'b0, d_q}) begin
          p_d = shift_p - {1'b0, d_q};
          a_d = {a_q[2:0], 1'b1};
        end else begin
          p_d = shift_p;
          a_d = shift_a;
        end
        cnt_d = cnt_q + 2'd1;
        if (cnt_q == 2'd3) begin
          valid_d = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      p_q     <= '0;
      a_q     <= '0;
      d_q     <= '0;
      cnt_q   <= '0;
      valid_q <= 1'b0;
      dbz_q   <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      p_q     <= p_d;
      a_q     <= a_d;
      d_q     <= d_d;
      cnt_q   <= cnt_d;
      valid_q <= valid_d;
      dbz_q   <= dbz_d;
      ovf_q   <= ovf_d;
    end
  end

  assign ready        = (state_q == IDLE);
  assign valid        = valid_q;
  assign quotientBus  = a_q;
  assign remainderBus = p_q[3:0];
  assign divByZero    = dbz_q;
  assign overflow     = ovf_q;

endmodule

// File: tb/tb_shift_sub_divider.sv
// Scoreboard bench for shift_sub_divider: stimulus pushes expected results, a negedge monitor
// pops and compares each completion, including the accept-to-valid latency.
module tb_shift_sub_divider;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic [7:0] dividendBus;
  logic [3:0] divisorBus;
  logic       ready;
  logic       valid;
  logic [3:0] quotientBus;
  logic [3:0] remainderBus;
  logic       divByZero;
  logic       overflow;

  shift_sub_divider dut (
    .clk          (clk),
    .rst          (rst),
    .start        (start),
    .dividendBus  (dividendBus),
    .divisorBus   (divisorBus),
    .ready        (ready),
    .valid        (valid),
    .quotientBus  (quotientBus),
    .remainderBus (remainderBus),
    .divByZero    (divByZero),
    .overflow     (overflow)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [3:0] q;
    logic [3:0] r;
    logic       dbz;
    logic       ovf;
    logic [3:0] lat;
  } exp_t;

  exp_t sb[$];
  exp_t e;
  int   pass_cnt  = 0;
  int   total_cnt = 0;
  int   cyc       = 0;
  int   acc_cyc   = 0;
  int   done_cnt  = 0;
  int   last_done = 0;
  int   prev_done = 0;
  logic prev_valid = 1'b0;

  function automatic void chk(input string name, input int act, input int exp);
    total_cnt++;
    if (act == exp) pass_cnt++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endfunction

  always @(posedge clk) cyc++;

  // Monitor: completion = rising valid seen on the falling edge
  always @(negedge clk) begin
    if (valid && !prev_valid) begin
      if (sb.size() == 0) begin
        total_cnt++;
        $display("FAIL unexpected_valid: got q=%0d r=%0d with empty scoreboard", quotientBus, remainderBus);
      end else begin
        e = sb.pop_front();
        chk("quotient",  int'(quotientBus),  int'(e.q));
        chk("remainder", int'(remainderBus), int'(e.r));
        chk("divByZero", int'(divByZero),    int'(e.dbz));
        chk("overflow",  int'(overflow),     int'(e.ovf));
        chk("latency",   cyc - acc_cyc,      int'(e.lat));
      end
      prev_done = last_done;
      last_done = cyc;
      done_cnt++;
    end
    prev_valid = valid;
    if (rst && ready && start) acc_cyc = cyc + 1;
  end

  task automatic wait_drain(input int budget);
    int n = 0;
    while (sb.size() != 0 && n < budget) begin
      @(posedge clk);
      n++;
    end
    if (sb.size() != 0) begin
      total_cnt++;
      $display("FAIL drain_timeout: got %0d pending expected 0", sb.size());
      sb.delete();
    end
    #1;
  endtask

  // Called at posedge+1; issues a single-cycle start pulse
  task automatic op(input logic [7:0] dvd, input logic [3:0] dvs, input logic [3:0] q,
                    input logic [3:0] r, input logic dbz, input logic ovf, input logic [3:0] lat);
    exp_t x;
    x.q = q; x.r = r; x.dbz = dbz; x.ovf = ovf; x.lat = lat;
    dividendBus = dvd;
    divisorBus  = dvs;
    start       = 1'b1;
    sb.push_back(x);
    @(posedge clk); #1;
    start = 1'b0;
    wait_drain(20);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    int base;
    rst = 1'b0; start = 1'b0; dividendBus = '0; divisorBus = '0;
    #12;
    chk("rst_ready",     int'(ready),        1);
    chk("rst_valid",     int'(valid),        0);
    chk("rst_quotient",  int'(quotientBus),  0);
    chk("rst_remainder", int'(remainderBus), 0);
    chk("rst_dbz",       int'(divByZero),    0);
    chk("rst_ovf",       int'(overflow),     0);
    @(posedge clk); #1;
    rst = 1'b1;

    op(8'd100, 4'd7,  4'd14, 4'd2,  1'b0, 1'b0, 4'd5);
    op(8'd45,  4'd3,  4'd15, 4'd0,  1'b0, 1'b0, 4'd5);
    op(8'd200, 4'd0,  4'hF,  4'd0,  1'b1, 1'b0, 4'd1);
    repeat (3) @(posedge clk);
    #1;
    chk("dbz_held",   int'(divByZero), 1);
    chk("valid_held", int'(valid),     1);
    op(8'd112, 4'd7,  4'hF,  4'd0,  1'b0, 1'b1, 4'd1);
    op(8'd9,   4'd2,  4'd4,  4'd1,  1'b0, 1'b0, 4'd5);
    op(8'd255, 4'd15, 4'hF,  4'd0,  1'b0, 1'b1, 4'd1);
    op(8'd239, 4'd15, 4'd15, 4'd14, 1'b0, 1'b0, 4'd5);
    op(8'd0,   4'd1,  4'd0,  4'd0,  1'b0, 1'b0, 4'd5);

    // Start pulse while busy is dropped, not queued
    base = done_cnt;
    dividendBus = 8'd100; divisorBus = 4'd7; start = 1'b1;
    sb.push_back('{q: 4'd14, r: 4'd2, dbz: 1'b0, ovf: 1'b0, lat: 4'd5});
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk); #1;
    dividendBus = 8'd45; divisorBus = 4'd3; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    wait_drain(20);
    repeat (8) @(posedge clk);
    #1;
    chk("busy_start_ignored", done_cnt - base, 1);
    chk("idle_ready", int'(ready), 1);

    // Reset during the second CALC cycle aborts the operation
    dividendBus = 8'd100; divisorBus = 4'd7; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b0;
    #1;
    chk("abort_ready",     int'(ready),        1);
    chk("abort_valid",     int'(valid),        0);
    chk("abort_quotient",  int'(quotientBus),  0);
    chk("abort_remainder", int'(remainderBus), 0);
    @(posedge clk); #1;
    rst = 1'b1;
    op(8'd45, 4'd3, 4'd15, 4'd0, 1'b0, 1'b0, 4'd5);

    // start held high: back-to-back, operand change while busy applies to the next op only
    base = done_cnt;
    sb.push_back('{q: 4'd14, r: 4'd2, dbz: 1'b0, ovf: 1'b0, lat: 4'd5});
    sb.push_back('{q: 4'd15, r: 4'd0, dbz: 1'b0, ovf: 1'b0, lat: 4'd5});
    dividendBus = 8'd100; divisorBus = 4'd7; start = 1'b1;
    @(posedge clk); #1;
    dividendBus = 8'd45; divisorBus = 4'd3;
    for (int n = 0; n < 20 && done_cnt == base; n++) @(negedge clk);
    @(posedge clk); #1;
    start = 1'b0;
    wait_drain(20);
    chk("b2b_completions", done_cnt - base, 2);
    chk("b2b_spacing", last_done - prev_done, 6);

    repeat (3) @(posedge clk);
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
